// File: rtl/round_counter.sv
// round_counter: round/address counter for the SHA hashing datapath.
// Start/clear control, per-run terminal count, one-shot or wrap mode,
// done pulse and message-schedule phase flag. All outputs registered.
// Optional: define ROUND_CNT_ERR_EN to add the sticky o_err output.
module round_counter #(
    parameter int unsigned CNT_SIZE  = 6,
    parameter int unsigned MAX_CNT   = 63,
    parameter int unsigned SCHED_LEN = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic                i_clear,
    input  logic                i_cnt_en,
    input  logic                i_wrap_mode,
    input  logic [CNT_SIZE-1:0] i_max_cnt,
    output logic [CNT_SIZE-1:0] o_count,
    output logic                o_flag,
    output logic                o_done,
    output logic                o_busy,
`ifdef ROUND_CNT_ERR_EN
    output logic                o_sched,
    output logic                o_err
`else
    output logic                o_sched
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_SIZE-1:0] r_count;
    logic [CNT_SIZE-1:0] w_count_nxt;
    logic [CNT_SIZE-1:0] r_max;
    logic [CNT_SIZE-1:0] w_max_nxt;
    logic [CNT_SIZE-1:0] w_start_max;
    logic                r_wrap;
    logic                w_wrap_nxt;
    logic                w_done_nxt;
    logic                r_flag;
    logic                r_done;
    logic                r_busy;
    logic                r_sched;

    // A zero terminal count at start selects the default terminal
    assign w_start_max = (i_max_cnt == '0) ? CNT_SIZE'(MAX_CNT) : i_max_cnt;

    // Next-state, next-count and latch logic; clear overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_max_nxt   = r_max;
        w_wrap_nxt  = r_wrap;
        w_done_nxt  = 1'b0;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_count_nxt = '0;
                        w_max_nxt   = w_start_max;
                        w_wrap_nxt  = i_wrap_mode;
                    end
                end
                S_RUN: begin
                    if (i_cnt_en) begin
                        if (r_count == r_max) begin
                            w_done_nxt = 1'b1;
                            if (r_wrap) begin
                                w_count_nxt = '0;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // State, counter and registered status outputs derived from next values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_max   <= CNT_SIZE'(MAX_CNT);
            r_wrap  <= 1'b0;
            r_flag  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_sched <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_max   <= w_max_nxt;
            r_wrap  <= w_wrap_nxt;
            r_flag  <= (w_state_nxt != S_IDLE) && (w_count_nxt == w_max_nxt);
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_sched <= (w_state_nxt == S_RUN) && (32'(w_count_nxt) < SCHED_LEN);
        end
    end

    assign o_count = r_count;
    assign o_flag  = r_flag;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_sched = r_sched;

`ifdef ROUND_CNT_ERR_EN
    logic r_err;
    logic w_err_set;

    // Protocol misuse: start while running, or enable while idle
    assign w_err_set = ((r_state == S_RUN) && i_start) || ((r_state == S_IDLE) && i_cnt_en);

    // Sticky error flag, cleared only by clear or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (i_clear) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_round_counter.sv
// Directed self-checking bench for round_counter (default parameters).
module tb_round_counter;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_start;
    logic         i_clear;
    logic         i_cnt_en;
    logic         i_wrap_mode;
    logic [W-1:0] i_max_cnt;
    logic [W-1:0] o_count;
    logic         o_flag;
    logic         o_done;
    logic         o_busy;
    logic         o_sched;
`ifdef ROUND_CNT_ERR_EN
    logic         o_err;
`endif

    int checks = 0;
    int errors = 0;

    round_counter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_clear    (i_clear),
        .i_cnt_en   (i_cnt_en),
        .i_wrap_mode(i_wrap_mode),
        .i_max_cnt  (i_max_cnt),
        .o_count    (o_count),
        .o_flag     (o_flag),
        .o_done     (o_done),
        .o_busy     (o_busy),
`ifdef ROUND_CNT_ERR_EN
        .o_sched    (o_sched),
        .o_err      (o_err)
`else
        .o_sched    (o_sched)
`endif
    );

    always #5 clk = ~clk;

    // Pack {count, flag, done, busy, sched} for compact comparisons
    function automatic logic [W+3:0] pk(input logic [W-1:0] c, input logic f,
                                        input logic d, input logic b, input logic s);
        return {c, f, d, b, s};
    endfunction

    function automatic logic [W+3:0] obs();
        return {o_count, o_flag, o_done, o_busy, o_sched};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [W-1:0] mx, input logic wr, input logic en);
        i_max_cnt   = mx;
        i_wrap_mode = wr;
        i_cnt_en    = en;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic do_clear();
        i_cnt_en = 1'b0;
        i_clear  = 1'b1;
        tick();
        i_clear  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_start = 0; i_clear = 0; i_cnt_en = 0;
        i_wrap_mode = 0; i_max_cnt = '0;
        #12;
        checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] c;
        start_run('0, 1'b0, 1'b1);
        checks++;
        if (obs() !== pk(0, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL oneshot_first: got %h expected %h", obs(), pk(0, 0, 0, 1, 1));
        end
        for (int k = 1; k <= 63; k++) begin
            tick();
            c = W'(k);
            checks++;
            if (obs() !== pk(c, k == 63, 0, 1, k < 16)) begin
                errors++;
                $display("FAIL oneshot_k%0d: got %h expected %h", k, obs(), pk(c, k == 63, 0, 1, k < 16));
            end
        end
        tick();
        checks++;
        if (obs() !== pk(63, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL oneshot_done: got %h expected %h", obs(), pk(63, 1, 1, 0, 0));
        end
        tick();
        checks++;
        if (obs() !== pk(63, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL oneshot_hold: got %h expected %h", obs(), pk(63, 1, 0, 0, 0));
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] c;
        int pulses = 0;
        start_run(6'd5, 1'b1, 1'b1);
        checks++;
        if (obs() !== pk(0, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL wrap_first: got %h expected %h", obs(), pk(0, 0, 0, 1, 1));
        end
        for (int k = 1; k < 20; k++) begin
            tick();
            c = W'(k % 6);
            if (o_done === 1'b1) pulses++;
            checks++;
            if (obs() !== pk(c, (k % 6) == 5, (k % 6) == 0, 1, 1)) begin
                errors++;
                $display("FAIL wrap_k%0d: got %h expected %h", k, obs(), pk(c, (k % 6) == 5, (k % 6) == 0, 1, 1));
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d expected 3", pulses);
        end
        do_clear();
    endtask

    task automatic test_pause();
        start_run(6'd10, 1'b0, 1'b1);
        repeat (4) tick();
        checks++;
        if (obs() !== pk(4, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL pause_at4: got %h expected %h", obs(), pk(4, 0, 0, 1, 1));
        end
        i_cnt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs() !== pk(4, 0, 0, 1, 1)) begin
                errors++;
                $display("FAIL pause_hold%0d: got %h expected %h", k, obs(), pk(4, 0, 0, 1, 1));
            end
        end
        i_cnt_en = 1'b1;
        tick();
        checks++;
        if (obs() !== pk(5, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL pause_resume: got %h expected %h", obs(), pk(5, 0, 0, 1, 1));
        end
        do_clear();
    endtask

    task automatic test_clear_start();
        start_run('0, 1'b0, 1'b1);
        repeat (30) tick();
        checks++;
        if (obs() !== pk(30, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL clr_at30: got %h expected %h", obs(), pk(30, 0, 0, 1, 0));
        end
        i_clear = 1'b1;
        i_start = 1'b1;
        tick();
        i_clear = 1'b0;
        i_start = 1'b0;
        checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL clr_beats_start: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
        i_cnt_en = 1'b0;
        tick();
        checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL clr_idle_hold: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_async_reset();
        start_run('0, 1'b0, 1'b1);
        repeat (40) tick();
        checks++;
        if (obs() !== pk(40, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL arst_at40: got %h expected %h", obs(), pk(40, 0, 0, 1, 0));
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL arst_immediate: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
        i_cnt_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        start_run('0, 1'b0, 1'b1);
        repeat (63) tick();
        checks++;
        if (obs() !== pk(63, 1, 0, 1, 0)) begin
            errors++;
            $display("FAIL arst_rerun63: got %h expected %h", obs(), pk(63, 1, 0, 1, 0));
        end
        tick();
        checks++;
        if (obs() !== pk(63, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL arst_rerun_done: got %h expected %h", obs(), pk(63, 1, 1, 0, 0));
        end
        do_clear();
    endtask

    task automatic test_start_in_run();
        start_run(6'd5, 1'b0, 1'b0);
`ifdef ROUND_CNT_ERR_EN
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: got %b expected 0", o_err);
        end
`endif
        i_cnt_en = 1'b1;
        repeat (2) tick();
        i_max_cnt   = 6'd9;
        i_wrap_mode = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        checks++;
        if (obs() !== pk(3, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL sir_ignored: got %h expected %h", obs(), pk(3, 0, 0, 1, 1));
        end
`ifdef ROUND_CNT_ERR_EN
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b expected 1", o_err);
        end
`endif
        repeat (2) tick();
        checks++;
        if (obs() !== pk(5, 1, 0, 1, 1)) begin
            errors++;
            $display("FAIL sir_term5: got %h expected %h", obs(), pk(5, 1, 0, 1, 1));
        end
        tick();
        checks++;
        if (obs() !== pk(5, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL sir_oneshot_kept: got %h expected %h", obs(), pk(5, 1, 1, 0, 0));
        end
`ifdef ROUND_CNT_ERR_EN
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", o_err);
        end
`endif
        do_clear();
`ifdef ROUND_CNT_ERR_EN
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", o_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_wrap();
        test_pause();
        test_clear_start();
        test_async_reset();
        test_start_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
